cdb_arbiter: RTL and testbench

CDB_ARBITER -- requirements
Module: cdb_arbiter

---
 rtl/cdb_arbiter_pkg.sv | 34 +++
 rtl/cdb_arbiter_result_fifo.sv | 56 +++++
 rtl/cdb_arbiter.sv | 108 ++++++++++
 tb/tb_cdb_arbiter.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/cdb_arbiter_pkg.sv
// Shared types for the CDB path: reservation-station entry and broadcast result,
// plus the round-robin pointer helper used by the arbiter.
`ifndef PHYSICAL_REG_NUM_WIDTH
`define PHYSICAL_REG_NUM_WIDTH 6
`endif
`ifndef REG_VAL_WIDTH
`define REG_VAL_WIDTH 32
`endif

package cdb_arbiter_pkg;

  typedef struct packed {
    logic                               valid;
    logic [3:0]                         op;
    logic [`PHYSICAL_REG_NUM_WIDTH-1:0] dst_reg_addr;
    logic [`PHYSICAL_REG_NUM_WIDTH-1:0] src1_tag;
    logic                               src1_ready;
    logic [`REG_VAL_WIDTH-1:0]          src1_val;
    logic [`PHYSICAL_REG_NUM_WIDTH-1:0] src2_tag;
    logic                               src2_ready;
    logic [`REG_VAL_WIDTH-1:0]          src2_val;
  } reservation_station_t;

  typedef struct packed {
    logic [`PHYSICAL_REG_NUM_WIDTH-1:0] dst_reg_addr;
    logic [`REG_VAL_WIDTH-1:0]          register_val;
  } cdb_result_t;

  // Next search start after granting port k out of n ports.
  function automatic int unsigned rr_next(input int unsigned k, input int unsigned n);
    return (k + 1 >= n) ? 0 : k + 1;
  endfunction

endpackage

// File: rtl/cdb_arbiter_result_fifo.sv
// Per-FU result buffer: power-of-two circular FIFO with occupancy count.
// Push is ignored when full and pop when empty, so callers may assert them freely.
module result_fifo
  import cdb_arbiter_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic                     pop,
  input  cdb_result_t              din,
  output cdb_result_t              dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  cdb_result_t     r_mem [DEPTH];
  logic [AW-1:0]   r_wr_ptr;
  logic [AW-1:0]   r_rd_ptr;
  logic [CW-1:0]   r_count;
  logic            w_push;
  logic            w_pop;

  assign full   = (r_count == CW'(DEPTH));
  assign empty  = (r_count == '0);
  assign count  = r_count;
  assign dout   = r_mem[r_rd_ptr];
  assign w_push = push && !full;
  assign w_pop  = pop && !empty;

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= din;
  end

endmodule

// File: rtl/cdb_arbiter.sv
// Common data bus arbiter: buffers each FU's results and broadcasts one per cycle
// through a registered CDB output, choosing among FUs round-robin.
module cdb_arbiter
  import cdb_arbiter_pkg::*;
#(
  parameter int FU_NUM       = 4,
  parameter int BUF_DEPTH    = 2,
  parameter int FU_IDX_WIDTH = (FU_NUM <= 1) ? 1 : $clog2(FU_NUM)
) (
  input  logic                                           clk,
  input  logic                                           reset,
  input  logic [FU_NUM-1:0]                              fu_valid,
  output logic [FU_NUM-1:0]                              fu_ready,
  input  logic [FU_NUM-1:0][`PHYSICAL_REG_NUM_WIDTH-1:0] fu_dst_reg_addr,
  input  logic [FU_NUM-1:0][`REG_VAL_WIDTH-1:0]          fu_result_val,
  output logic                                           cdb_valid,
  output logic [`PHYSICAL_REG_NUM_WIDTH-1:0]             cdb_register_addr,
  output logic [`REG_VAL_WIDTH-1:0]                      cdb_register_val,
  input  logic                                           cdb_ready,
  output logic [FU_IDX_WIDTH-1:0]                        cdb_grant_idx
);
  localparam int CW = $clog2(BUF_DEPTH) + 1;

  cdb_result_t               w_head  [FU_NUM];
  logic [CW-1:0]             w_count [FU_NUM];
  logic [FU_NUM-1:0]         w_empty;
  logic [FU_NUM-1:0]         w_full;
  logic [FU_NUM-1:0]         w_push;
  logic [FU_NUM-1:0]         w_pop;
  logic                      w_load;
  logic                      w_found;
  logic [FU_IDX_WIDTH-1:0]   w_grant;

  logic                      r_cdb_valid;
  cdb_result_t               r_cdb_data;
  logic [FU_IDX_WIDTH-1:0]   r_grant_idx;
  logic [FU_IDX_WIDTH-1:0]   r_rr_ptr;

  for (genvar i = 0; i < FU_NUM; i++) begin : g_fu
    cdb_result_t w_din;
    assign w_din.dst_reg_addr = fu_dst_reg_addr[i];
    assign w_din.register_val = fu_result_val[i];
    // Ready comes from registered occupancy only, so a same-cycle pop never frees a slot.
    assign fu_ready[i] = (w_count[i] < CW'(BUF_DEPTH));
    assign w_push[i]   = fu_valid[i] && fu_ready[i];

    result_fifo #(.DEPTH(BUF_DEPTH)) u_fifo (
      .clk   (clk),
      .reset (reset),
      .push  (w_push[i]),
      .pop   (w_pop[i]),
      .din   (w_din),
      .dout  (w_head[i]),
      .full  (w_full[i]),
      .empty (w_empty[i]),
      .count (w_count[i])
    );
  end

  assign w_load = !r_cdb_valid || cdb_ready;

  always_comb begin
    int                      j;
    logic [FU_IDX_WIDTH-1:0] w_j;
    w_found = 1'b0;
    w_grant = '0;
    j       = 0;
    w_j     = '0;
    for (int k = 0; k < FU_NUM; k++) begin
      j = int'(r_rr_ptr) + k;
      if (j >= FU_NUM) j = j - FU_NUM;
      w_j = FU_IDX_WIDTH'(j);
      if (!w_found && !w_empty[w_j]) begin
        w_found = 1'b1;
        w_grant = w_j;
      end
    end
  end

  always_comb begin
    w_pop = '0;
    if (w_load && w_found) w_pop[w_grant] = 1'b1;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_cdb_valid <= 1'b0;
      r_cdb_data  <= '0;
      r_grant_idx <= '0;
      r_rr_ptr    <= '0;
    end else if (w_load) begin
      if (w_found) begin
        r_cdb_valid <= 1'b1;
        r_cdb_data  <= w_head[w_grant];
        r_grant_idx <= w_grant;
        r_rr_ptr    <= FU_IDX_WIDTH'(rr_next(int'(w_grant), FU_NUM));
      end else begin
        r_cdb_valid <= 1'b0;
      end
    end
  end

  assign cdb_valid         = r_cdb_valid;
  assign cdb_register_addr = r_cdb_data.dst_reg_addr;
  assign cdb_register_val  = r_cdb_data.register_val;
  assign cdb_grant_idx     = r_grant_idx;

endmodule

// File: tb/tb_cdb_arbiter.sv
// Directed bench for cdb_arbiter: expected CDB transfers are queued at stimulus
// time and checked in order by a monitor that fires on each consumed transfer.
`ifndef PHYSICAL_REG_NUM_WIDTH
`define PHYSICAL_REG_NUM_WIDTH 6
`endif
`ifndef REG_VAL_WIDTH
`define REG_VAL_WIDTH 32
`endif

module tb_cdb_arbiter;
  localparam int AW = `PHYSICAL_REG_NUM_WIDTH;
  localparam int VW = `REG_VAL_WIDTH;

  logic                 clk = 1'b0;
  logic                 reset;
  logic [3:0]           fu_valid;
  logic [3:0]           fu_ready;
  logic [3:0][AW-1:0]   fu_dst_reg_addr;
  logic [3:0][VW-1:0]   fu_result_val;
  logic                 cdb_valid;
  logic [AW-1:0]        cdb_register_addr;
  logic [VW-1:0]        cdb_register_val;
  logic                 cdb_ready;
  logic [1:0]           cdb_grant_idx;

  int n_cmp = 0;
  int n_err = 0;
  logic [63:0] exp_q [$];

  cdb_arbiter dut (
    .clk               (clk),
    .reset             (reset),
    .fu_valid          (fu_valid),
    .fu_ready          (fu_ready),
    .fu_dst_reg_addr   (fu_dst_reg_addr),
    .fu_result_val     (fu_result_val),
    .cdb_valid         (cdb_valid),
    .cdb_register_addr (cdb_register_addr),
    .cdb_register_val  (cdb_register_val),
    .cdb_ready         (cdb_ready),
    .cdb_grant_idx     (cdb_grant_idx)
  );

  always #5 clk = ~clk;

  function automatic logic [63:0] pk(input int addr, input int val, input int idx);
    return {22'd0, 2'(idx), AW'(addr), VW'(val)};
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_reset();
    reset = 1'b0;
    #2;
    reset = 1'b1;
    tick();
  endtask

  task automatic drive(input int fu, input int addr, input int val);
    fu_dst_reg_addr[fu] = AW'(addr);
    fu_result_val[fu]   = VW'(val);
  endtask

  // Scoreboard monitor: every transfer the consumer accepts must match the queue head.
  always @(negedge clk) begin
    if (reset && cdb_valid && cdb_ready) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_transfer", pk(cdb_register_addr, cdb_register_val, cdb_grant_idx), 64'hDEAD);
      end else begin
        chk("cdb_transfer", pk(cdb_register_addr, cdb_register_val, cdb_grant_idx), exp_q.pop_front());
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: run did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b0;
    fu_valid = '0;
    fu_dst_reg_addr = '0;
    fu_result_val = '0;
    cdb_ready = 1'b1;
    repeat (2) tick();
    chk("rst_valid", 64'(cdb_valid), 64'd0);
    chk("rst_addr",  64'(cdb_register_addr), 64'd0);
    chk("rst_val",   64'(cdb_register_val), 64'd0);
    chk("rst_grant", 64'(cdb_grant_idx), 64'd0);
    chk("rst_ready", 64'(fu_ready), 64'hF);
    reset = 1'b1;
    tick();

    // Single result, latency and drop back to idle
    fu_valid = 4'b0100;
    drive(2, 5, 'hAB);
    exp_q.push_back(pk(5, 'hAB, 2));
    tick();
    fu_valid = '0;
    chk("lat_not_early", 64'(cdb_valid), 64'd0);
    tick();
    chk("lat_valid", 64'(cdb_valid), 64'd1);
    chk("lat_grant", 64'(cdb_grant_idx), 64'd2);
    tick();
    chk("lat_idle", 64'(cdb_valid), 64'd0);

    // All four FUs at once from a fresh rr pointer, one per cycle
    pulse_reset();
    fu_valid = 4'b1111;
    for (int i = 0; i < 4; i++) begin
      drive(i, 10 + i, 'h200 + i);
      exp_q.push_back(pk(10 + i, 'h200 + i, i));
    end
    tick();
    fu_valid = '0;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("rr4_valid", 64'(cdb_valid), 64'd1);
      chk("rr4_grant", 64'(cdb_grant_idx), 64'(i));
    end
    tick();
    chk("rr4_idle", 64'(cdb_valid), 64'd0);
    // rr pointer wrapped to 0: FU0 beats FU3
    fu_valid = 4'b1001;
    drive(0, 20, 'h300);
    drive(3, 23, 'h303);
    exp_q.push_back(pk(20, 'h300, 0));
    exp_q.push_back(pk(23, 'h303, 3));
    tick();
    fu_valid = '0;
    tick();
    chk("wrap_first", 64'(cdb_grant_idx), 64'd0);
    tick();
    chk("wrap_second", 64'(cdb_grant_idx), 64'd3);
    tick();

    // FU0 streaming cannot starve FU3
    pulse_reset();
    fu_valid = 4'b1001;
    drive(0, 30, 'h400);
    drive(3, 33, 'h4FF);
    exp_q.push_back(pk(30, 'h400, 0));
    exp_q.push_back(pk(33, 'h4FF, 3));
    exp_q.push_back(pk(30, 'h401, 0));
    exp_q.push_back(pk(30, 'h402, 0));
    tick();
    fu_valid = 4'b0001;
    drive(0, 30, 'h401);
    chk("stv_ready0_a", 64'(fu_ready[0]), 64'd1);
    tick();
    drive(0, 30, 'h402);
    chk("stv_ready0_b", 64'(fu_ready[0]), 64'd1);
    tick();
    fu_valid = '0;
    chk("stv_fu3_granted", 64'(cdb_grant_idx), 64'd3);
    chk("stv_ready0_full", 64'(fu_ready[0]), 64'd0);
    repeat (4) tick();
    chk("stv_idle", 64'(cdb_valid), 64'd0);

    // Back-pressure hold, then full FIFO with same-cycle pop refuses the push
    pulse_reset();
    cdb_ready = 1'b0;
    fu_valid = 4'b0010;
    drive(1, 40, 'h501);
    for (int i = 1; i <= 3; i++) exp_q.push_back(pk(40, 'h500 + i, 1));
    tick();
    chk("hold_ready_a", 64'(fu_ready[1]), 64'd1);
    drive(1, 40, 'h502);
    tick();
    chk("hold_loaded", 64'(cdb_valid), 64'd1);
    chk("hold_ready_b", 64'(fu_ready[1]), 64'd1);
    drive(1, 40, 'h503);
    tick();
    fu_valid = '0;
    chk("hold_ready_full", 64'(fu_ready[1]), 64'd0);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("hold_stable", pk(cdb_register_addr, cdb_register_val, cdb_grant_idx), pk(40, 'h501, 1));
    end
    cdb_ready = 1'b1;
    fu_valid = 4'b0010;
    drive(1, 41, 'h5EE);
    chk("full_pop_refuse", 64'(fu_ready[1]), 64'd0);
    tick();
    fu_valid = '0;
    chk("full_pop_count", 64'(fu_ready[1]), 64'd1);
    chk("full_pop_next", 64'(cdb_register_val), 64'h502);
    repeat (3) tick();
    chk("full_pop_idle", 64'(cdb_valid), 64'd0);

    // Asynchronous reset while full and valid discards everything
    cdb_ready = 1'b0;
    fu_valid = 4'b1111;
    for (int i = 0; i < 4; i++) drive(i, 50 + i, 'h600 + i);
    repeat (3) tick();
    fu_valid = '0;
    chk("pre_rst_ready", 64'(fu_ready), 64'h0);
    chk("pre_rst_valid", 64'(cdb_valid), 64'd1);
    #3;
    reset = 1'b0;
    #1;
    chk("async_valid", 64'(cdb_valid), 64'd0);
    chk("async_ready", 64'(fu_ready), 64'hF);
    chk("async_addr",  64'(cdb_register_addr), 64'd0);
    chk("async_val",   64'(cdb_register_val), 64'd0);
    chk("async_grant", 64'(cdb_grant_idx), 64'd0);
    tick();
    reset = 1'b1;
    cdb_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("post_rst_quiet", 64'(cdb_valid), 64'd0);
    end

    chk("queue_drained", 64'(exp_q.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
